robot_key_ctrl: RTL and testbench

Turns the PS/2 keyboard byte stream into the 4-bit `move_opr` command consumed by the robot movement block. Parses make/break/extended scan-code sequences with a small prefix FSM and keeps a per-key pressed flag for W/A/S/D and the four arrow keys. Sits between the PS/2 byte receiver and the robot movement block, in the 100 MHz `clk` domain.

---
 rtl/robot_pkg.sv | 71 +++++++
 rtl/scan_prefix_fsm.sv | 67 ++++++
 rtl/robot_key_ctrl.sv | 60 ++++++
 tb/tb_robot_key_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/robot_pkg.sv
// Shared constants and types for the PS/2 keyboard to robot movement path:
// scan codes, move_opr bit positions, prefix FSM states and key flag decoding.
package robot_pkg;

  localparam logic [7:0] SC_W      = 8'h1D;
  localparam logic [7:0] SC_S      = 8'h1B;
  localparam logic [7:0] SC_A      = 8'h1C;
  localparam logic [7:0] SC_D      = 8'h23;
  localparam logic [7:0] SC_UP     = 8'h75;
  localparam logic [7:0] SC_DOWN   = 8'h72;
  localparam logic [7:0] SC_LEFT   = 8'h6B;
  localparam logic [7:0] SC_RIGHT  = 8'h74;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_BAT    = 8'hAA;
  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_RESEND = 8'hFE;

  localparam int MV_UP = 3;
  localparam int MV_DN = 2;
  localparam int MV_LT = 1;
  localparam int MV_RT = 0;

  // Bit positions of the pressed flags.
  localparam int KEY_W     = 0;
  localparam int KEY_S     = 1;
  localparam int KEY_A     = 2;
  localparam int KEY_D     = 3;
  localparam int KEY_UP    = 4;
  localparam int KEY_DOWN  = 5;
  localparam int KEY_LEFT  = 6;
  localparam int KEY_RIGHT = 7;
  localparam int NUM_KEYS  = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } scan_state_t;

  typedef struct packed {
    logic       code_valid;
    logic       is_ext;
    logic       is_break;
    logic [7:0] code;
  } scan_evt_t;

  // One-hot flag mask for a completed code; zero for untracked codes.
  function automatic logic [NUM_KEYS-1:0] key_mask(input logic is_ext, input logic [7:0] code);
    key_mask = '0;
    if (!is_ext) begin
      case (code)
        SC_W:    key_mask[KEY_W] = 1'b1;
        SC_S:    key_mask[KEY_S] = 1'b1;
        SC_A:    key_mask[KEY_A] = 1'b1;
        SC_D:    key_mask[KEY_D] = 1'b1;
        default: key_mask = '0;
      endcase
    end else begin
      case (code)
        SC_UP:    key_mask[KEY_UP]    = 1'b1;
        SC_DOWN:  key_mask[KEY_DOWN]  = 1'b1;
        SC_LEFT:  key_mask[KEY_LEFT]  = 1'b1;
        SC_RIGHT: key_mask[KEY_RIGHT] = 1'b1;
        default:  key_mask = '0;
      endcase
    end
  endfunction

endpackage

// File: rtl/scan_prefix_fsm.sv
// Tracks E0/F0 prefixes in the PS/2 byte stream and reports each completed
// code in the same cycle as the strobe carrying its last byte.
module scan_prefix_fsm
  import robot_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  output scan_evt_t  evt,
  output logic       clear_all
);

  // Handshake: rx_valid is a one-cycle strobe with no ready; every strobed
  // byte is consumed in that cycle and the FSM holds when rx_valid is low.
  scan_state_t state_q;
  scan_state_t state_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    evt       = '0;
    clear_all = 1'b0;
    if (rx_valid) begin
      if (rx_byte == SC_BAT) begin
        clear_all = 1'b1;
        state_d   = ST_IDLE;
      end else if (rx_byte == SC_ACK || rx_byte == SC_RESEND) begin
        state_d = ST_IDLE;
      end else begin
        evt.code = rx_byte;
        case (state_q)
          ST_IDLE: begin
            if (rx_byte == SC_EXT)      state_d = ST_EXT;
            else if (rx_byte == SC_BRK) state_d = ST_BRK;
            else                        evt.code_valid = 1'b1;
          end
          ST_EXT: begin
            if (rx_byte == SC_BRK) begin
              state_d = ST_EXT_BRK;
            end else begin
              evt.code_valid = 1'b1;
              evt.is_ext     = 1'b1;
              state_d        = ST_IDLE;
            end
          end
          ST_BRK: begin
            evt.code_valid = 1'b1;
            evt.is_break   = 1'b1;
            state_d        = ST_IDLE;
          end
          default: begin
            evt.code_valid = 1'b1;
            evt.is_ext     = 1'b1;
            evt.is_break   = 1'b1;
            state_d        = ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/robot_key_ctrl.sv
// Converts parsed PS/2 key events into the registered 4-bit move_opr command
// and pulses key_event whenever a tracked pressed flag changes.
module robot_key_ctrl
  import robot_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  input  logic       enable,
  output logic [3:0] move_opr,
  output logic       key_event
);

  scan_evt_t             evt;
  logic                  clear_all;
  logic [NUM_KEYS-1:0]   flags_q;
  logic [NUM_KEYS-1:0]   flags_d;
  logic [NUM_KEYS-1:0]   mask;
  logic [3:0]            dir;

  scan_prefix_fsm u_fsm (
    .clk       (clk),
    .rst       (rst),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .evt       (evt),
    .clear_all (clear_all)
  );

  // Output registers are fed from the next flag values so a completed code
  // shows on move_opr one cycle after its last strobe.
  always_comb begin
    mask    = key_mask(evt.is_ext, evt.code);
    flags_d = flags_q;
    if (clear_all)            flags_d = '0;
    else if (evt.code_valid) begin
      if (evt.is_break) flags_d = flags_q & ~mask;
      else              flags_d = flags_q | mask;
    end
    dir        = '0;
    dir[MV_UP] = flags_d[KEY_W] | flags_d[KEY_UP];
    dir[MV_DN] = flags_d[KEY_S] | flags_d[KEY_DOWN];
    dir[MV_LT] = flags_d[KEY_A] | flags_d[KEY_LEFT];
    dir[MV_RT] = flags_d[KEY_D] | flags_d[KEY_RIGHT];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flags_q   <= '0;
      move_opr  <= '0;
      key_event <= 1'b0;
    end else begin
      flags_q   <= flags_d;
      move_opr  <= enable ? dir : 4'b0000;
      key_event <= (flags_d != flags_q);
    end
  end

endmodule

// File: tb/tb_robot_key_ctrl.sv
// Bench for robot_key_ctrl: directed scenarios plus random byte streams,
// checked against a prefix-flag and pressed-key model.
module tb_robot_key_ctrl;
  import robot_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_valid = 1'b0;
  logic       enable = 1'b1;
  logic [3:0] move_opr;
  logic       key_event;

  int checks = 0;
  int errors = 0;

  // Model: key order W S A D Up Down Left Right.
  bit pressed [8];
  bit m_e0;
  bit m_f0;

  robot_key_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .enable    (enable),
    .move_opr  (move_opr),
    .key_event (key_event)
  );

  always #5 clk = ~clk;

  function automatic int key_idx(input bit ext, input logic [7:0] c);
    case ({ext, c})
      9'h01D:  return 0;
      9'h01B:  return 1;
      9'h01C:  return 2;
      9'h023:  return 3;
      9'h175:  return 4;
      9'h172:  return 5;
      9'h16B:  return 6;
      9'h174:  return 7;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) pressed[i] = 1'b0;
    m_e0 = 1'b0;
    m_f0 = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] b, output logic changed);
    int k;
    changed = 1'b0;
    if (b == 8'hAA) begin
      for (int i = 0; i < 8; i++) begin
        if (pressed[i]) changed = 1'b1;
        pressed[i] = 1'b0;
      end
      m_e0 = 1'b0;
      m_f0 = 1'b0;
    end else if (b == 8'hFA || b == 8'hFE) begin
      m_e0 = 1'b0;
      m_f0 = 1'b0;
    end else if (b == 8'hE0 && !m_e0 && !m_f0) begin
      m_e0 = 1'b1;
    end else if (b == 8'hF0 && !m_f0) begin
      m_f0 = 1'b1;
    end else begin
      k = key_idx(m_e0, b);
      if (k >= 0 && pressed[k] != !m_f0) begin
        pressed[k] = !m_f0;
        changed    = 1'b1;
      end
      m_e0 = 1'b0;
      m_f0 = 1'b0;
    end
  endtask

  // Drives one cycle and returns what the outputs must be just after the edge.
  task automatic drive(input bit v, input logic [7:0] b, input bit en,
                       output logic [3:0] e_mv, output logic e_ev);
    @(negedge clk);
    rx_valid = v;
    rx_byte  = b;
    enable   = en;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    e_ev = 1'b0;
    if (v) model_byte(b, e_ev);
    e_mv = en ? {pressed[0] | pressed[4], pressed[1] | pressed[5],
                 pressed[2] | pressed[6], pressed[3] | pressed[7]} : 4'b0000;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (move_opr !== 4'b0000) begin
        errors++;
        $display("FAIL reset_move_opr got %b want 0000", move_opr);
      end
      checks++;
      if (key_event !== 1'b0) begin
        errors++;
        $display("FAIL reset_key_event got %b want 0", key_event);
      end
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_single_key();
    logic [7:0] seq [3] = '{8'h1D, 8'hF0, 8'h1D};
    logic [3:0] e_mv;
    logic       e_ev;
    int         ev_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, seq[i], 1'b1, e_mv, e_ev);
      checks++;
      if (move_opr !== e_mv || key_event !== e_ev) begin
        errors++;
        $display("FAIL single_key[%0d] got %b/%b want %b/%b", i, move_opr, key_event, e_mv, e_ev);
      end
      if (i == 0) begin
        checks++;
        if (move_opr !== 4'b1000 || key_event !== 1'b1) begin
          errors++;
          $display("FAIL single_key_press got %b/%b want 1000/1", move_opr, key_event);
        end
      end
      if (key_event === 1'b1) ev_cnt++;
    end
    drive(1'b0, 8'h00, 1'b1, e_mv, e_ev);
    checks++;
    if (move_opr !== 4'b0000 || key_event !== 1'b0 || ev_cnt != 2) begin
      errors++;
      $display("FAIL single_key_release got %b/%b events %0d want 0000/0 events 2", move_opr, key_event, ev_cnt);
    end
  endtask

  task automatic test_ext_key();
    logic [7:0] seq [8] = '{8'hE0, 8'h74, 8'h23, 8'hE0, 8'hF0, 8'h74, 8'hF0, 8'h23};
    logic [3:0] e_mv;
    logic       e_ev;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, seq[i], 1'b1, e_mv, e_ev);
      checks++;
      if (move_opr !== e_mv || key_event !== e_ev) begin
        errors++;
        $display("FAIL ext_key[%0d] got %b/%b want %b/%b", i, move_opr, key_event, e_mv, e_ev);
      end
      if (i == 5) begin
        checks++;
        if (move_opr !== 4'b0001 || key_event !== 1'b1) begin
          errors++;
          $display("FAIL ext_release_keeps_right got %b/%b want 0001/1", move_opr, key_event);
        end
      end
    end
    checks++;
    if (move_opr !== 4'b0000) begin
      errors++;
      $display("FAIL ext_key_final got %b want 0000", move_opr);
    end
  endtask

  task automatic test_typematic();
    logic [3:0] e_mv;
    logic       e_ev;
    int         ev_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      drive(i % 2 == 0, 8'h1D, 1'b1, e_mv, e_ev);
      checks++;
      if (move_opr !== 4'b1000 || key_event !== e_ev) begin
        errors++;
        $display("FAIL typematic[%0d] got %b/%b want 1000/%b", i, move_opr, key_event, e_ev);
      end
      if (key_event === 1'b1) ev_cnt++;
    end
    checks++;
    if (ev_cnt != 1) begin
      errors++;
      $display("FAIL typematic_events got %0d want 1", ev_cnt);
    end
    drive(1'b1, 8'hF0, 1'b1, e_mv, e_ev);
    drive(1'b1, 8'h1D, 1'b1, e_mv, e_ev);
  endtask

  task automatic test_bat_clear();
    logic [7:0] seq [7] = '{8'h1D, 8'h1C, 8'hE0, 8'h74, 8'hAA, 8'hE0, 8'h72};
    logic [3:0] e_mv;
    logic       e_ev;
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, seq[i], 1'b1, e_mv, e_ev);
      checks++;
      if (move_opr !== e_mv || key_event !== e_ev) begin
        errors++;
        $display("FAIL bat[%0d] got %b/%b want %b/%b", i, move_opr, key_event, e_mv, e_ev);
      end
      if (i == 3 && move_opr !== 4'b1011) begin
        errors++;
        $display("FAIL bat_held got %b want 1011", move_opr);
      end
      if (i == 4) begin
        checks++;
        if (move_opr !== 4'b0000 || dut.u_fsm.state_q !== ST_IDLE) begin
          errors++;
          $display("FAIL bat_clear got %b state %0d want 0000 state 0", move_opr, dut.u_fsm.state_q);
        end
      end
    end
    checks++;
    if (move_opr !== 4'b0100) begin
      errors++;
      $display("FAIL bat_then_down got %b want 0100", move_opr);
    end
    drive(1'b1, 8'hAA, 1'b1, e_mv, e_ev);
  endtask

  task automatic test_enable_gate();
    logic [3:0] e_mv;
    logic       e_ev;
    drive(1'b1, 8'h23, 1'b1, e_mv, e_ev);
    checks++;
    if (move_opr !== 4'b0001) begin
      errors++;
      $display("FAIL enable_hold_d got %b want 0001", move_opr);
    end
    for (int i = 0; i < 5; i++) begin
      drive(i == 1 || i == 3, (i == 1) ? 8'hF0 : 8'h23, 1'b0, e_mv, e_ev);
      checks++;
      if (move_opr !== 4'b0000 || key_event !== e_ev) begin
        errors++;
        $display("FAIL enable_low[%0d] got %b/%b want 0000/%b", i, move_opr, key_event, e_ev);
      end
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 8'h00, 1'b1, e_mv, e_ev);
      checks++;
      if (move_opr !== 4'b0000 || move_opr !== e_mv) begin
        errors++;
        $display("FAIL enable_high[%0d] got %b want 0000", i, move_opr);
      end
    end
  endtask

  task automatic test_reset_mid_sequence();
    logic [3:0] e_mv;
    logic       e_ev;
    drive(1'b1, 8'h1B, 1'b1, e_mv, e_ev);
    drive(1'b1, 8'hE0, 1'b1, e_mv, e_ev);
    drive(1'b1, 8'hF0, 1'b1, e_mv, e_ev);
    test_reset();
    drive(1'b1, 8'h75, 1'b1, e_mv, e_ev);
    checks++;
    if (move_opr !== 4'b0000 || key_event !== 1'b0 || move_opr !== e_mv) begin
      errors++;
      $display("FAIL reset_mid_seq got %b/%b want 0000/0", move_opr, key_event);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq [10] = '{8'hE0, 8'h6B, 8'h1B, 8'hE0, 8'h75, 8'hF0, 8'h1B, 8'hE0, 8'hF0, 8'h6B};
    logic [3:0] e_mv;
    logic       e_ev;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, seq[i], 1'b1, e_mv, e_ev);
      checks++;
      if (move_opr !== e_mv || key_event !== e_ev) begin
        errors++;
        $display("FAIL back_to_back[%0d] got %b/%b want %b/%b", i, move_opr, key_event, e_mv, e_ev);
      end
    end
    checks++;
    if (move_opr !== 4'b1000) begin
      errors++;
      $display("FAIL back_to_back_final got %b want 1000", move_opr);
    end
  endtask

  task automatic test_random();
    logic [7:0] pool [14] = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h75, 8'h72, 8'h6B,
                             8'h74, 8'hE0, 8'hF0, 8'hAA, 8'hFA, 8'hFE, 8'hE1};
    logic [3:0] e_mv;
    logic       e_ev;
    logic [7:0] b;
    bit         v;
    bit         en;
    int         sel;
    for (int i = 0; i < 2000; i++) begin
      sel = $urandom_range(0, 19);
      if (sel < 8)       b = pool[sel];
      else if (sel < 12) b = pool[8 + (sel % 2)];
      else if (sel < 18) b = pool[$urandom_range(0, 13)];
      else               b = 8'($urandom_range(0, 255));
      v  = ($urandom_range(0, 9) < 8);
      en = ($urandom_range(0, 9) < 9);
      drive(v, b, en, e_mv, e_ev);
      checks++;
      if (move_opr !== e_mv || key_event !== e_ev) begin
        errors++;
        $display("FAIL random[%0d] byte %h got %b/%b want %b/%b", i, b, move_opr, key_event, e_mv, e_ev);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_key();
    test_ext_key();
    test_typematic();
    test_bat_clear();
    test_enable_gate();
    test_reset_mid_sequence();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
